// File: rtl/mkmif_pkg.sv
// Shared constants for the MKM SPI link: 23K640 opcodes, status mode encodings and
// the responder FSM states.
package mkmif_pkg;

    localparam logic [7:0] SPI_READ_DATA_CMD    = 8'h03;
    localparam logic [7:0] SPI_WRITE_DATA_CMD   = 8'h02;
    localparam logic [7:0] SPI_READ_STATUS_CMD  = 8'h05;
    localparam logic [7:0] SPI_WRITE_STATUS_CMD = 8'h01;

    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_RDSR,
        ST_WRSR,
        ST_IGNORE
    } state_t;

endpackage

// File: rtl/mkmif_sram_mem.sv
// Single-port byte array with synchronous read and write; the read returns the
// old contents when the same address is written in the same cycle.
module mkmif_sram_mem #(
    parameter int ADDR_BITS = 13
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [7:0]           i_wdata,
    output logic [7:0]           o_rdata
);

    logic [7:0] r_mem [2**ADDR_BITS];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mkmif_spi_sram.sv
// SPI mode-0 slave emulating a 23K640 serial SRAM (READ/WRITE/RDSR/WRSR) on top of
// an internal byte array. All SPI pins are oversampled in the clk domain.
module mkmif_spi_sram
    import mkmif_pkg::*;
#(
    parameter int ADDR_BITS  = 13,
    parameter int PAGE_BYTES = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_di,
    output logic       spi_do,
    output logic [7:0] status,
    output logic       cmd_err
);

    localparam int PAGE_BITS = $clog2(PAGE_BYTES);

    // Index [1] is the synchronized value; [2] is its one-cycle delay for edge detect.
    logic [2:0] r_sclk_sync;
    logic [2:0] r_cs_sync;
    logic [1:0] r_di_sync;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [3:0]             r_bit_cnt;
    logic [15:0]            r_shift_in;
    logic [7:0]             r_shift_out;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [ADDR_BITS-1:0]   w_addr_next;
    logic [ADDR_BITS-1:0]   w_addr_adv;
    logic [7:0]             r_status;
    logic [7:0]             w_status_next;
    logic                   r_is_read;
    logic                   w_is_read_next;
    logic                   r_cmd_err;
    logic                   w_cmd_err;
    logic                   r_do;
    logic                   r_load_pend;
    logic                   w_load_rd;
    logic                   w_load_status;
    logic                   w_mem_we;
    logic [ADDR_BITS-1:0]   w_mem_addr;
    logic [7:0]             w_mem_rdata;

    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic                   w_cs_high;
    logic                   w_di;
    logic                   w_last_bit;
    logic                   w_field_done;
    logic                   w_byte_mode;
    logic                   w_shifting_out;
    logic [7:0]             w_shift_byte;
    logic [15:0]            w_shift_word;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sclk_sync <= 3'b000;
            r_cs_sync   <= 3'b111;
            r_di_sync   <= 2'b00;
        end else begin
            r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
            r_di_sync   <= {r_di_sync[0], spi_di};
        end
    end

    assign w_sclk_rise  = r_sclk_sync[1] & ~r_sclk_sync[2];
    assign w_sclk_fall  = ~r_sclk_sync[1] & r_sclk_sync[2];
    assign w_cs_fall    = ~r_cs_sync[1] & r_cs_sync[2];
    assign w_cs_rise    = r_cs_sync[1] & ~r_cs_sync[2];
    assign w_cs_high    = r_cs_sync[1];
    assign w_di         = r_di_sync[1];

    // The address field is 16 bits; every other field is one byte.
    assign w_last_bit   = (r_state == ST_ADDR) ? (r_bit_cnt == 4'd15) : (r_bit_cnt == 4'd7);
    assign w_field_done = w_sclk_rise & w_last_bit;
    assign w_shift_byte = {r_shift_in[6:0], w_di};
    assign w_shift_word = {r_shift_in[14:0], w_di};
    assign w_byte_mode  = (r_status[7:6] != MODE_SEQ) && (r_status[7:6] != MODE_PAGE);

    always_comb begin
        w_addr_adv = r_addr;
        if (r_status[7:6] == MODE_SEQ) begin
            w_addr_adv = r_addr + 1'b1;
        end else if (r_status[7:6] == MODE_PAGE) begin
            w_addr_adv[PAGE_BITS-1:0] = r_addr[PAGE_BITS-1:0] + 1'b1;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_addr_next    = r_addr;
        w_status_next  = r_status;
        w_is_read_next = r_is_read;
        w_cmd_err      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr     = r_addr;
        w_load_rd      = 1'b0;
        w_load_status  = 1'b0;
        if (w_cs_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cs_fall) w_state_next = ST_CMD;
                end
                ST_CMD: begin
                    if (w_field_done) begin
                        case (w_shift_byte)
                            SPI_READ_DATA_CMD: begin
                                w_state_next   = ST_ADDR;
                                w_is_read_next = 1'b1;
                            end
                            SPI_WRITE_DATA_CMD: begin
                                w_state_next   = ST_ADDR;
                                w_is_read_next = 1'b0;
                            end
                            SPI_READ_STATUS_CMD: begin
                                w_state_next  = ST_RDSR;
                                w_load_status = 1'b1;
                            end
                            SPI_WRITE_STATUS_CMD: w_state_next = ST_WRSR;
                            default: begin
                                w_state_next = ST_IGNORE;
                                w_cmd_err    = 1'b1;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (w_field_done) begin
                        w_addr_next = w_shift_word[ADDR_BITS-1:0];
                        if (r_is_read) begin
                            w_state_next = ST_RD_DATA;
                            w_mem_addr   = w_shift_word[ADDR_BITS-1:0];
                            w_load_rd    = 1'b1;
                        end else begin
                            w_state_next = ST_WR_DATA;
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (w_field_done) begin
                        if (w_byte_mode) begin
                            w_state_next = ST_IGNORE;
                        end else begin
                            w_addr_next = w_addr_adv;
                            w_mem_addr  = w_addr_adv;
                            w_load_rd   = 1'b1;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (w_field_done) begin
                        w_mem_we = 1'b1;
                        if (w_byte_mode) w_state_next = ST_IGNORE;
                        else             w_addr_next  = w_addr_adv;
                    end
                end
                ST_RDSR: begin
                    if (w_field_done) w_load_status = 1'b1;
                end
                ST_WRSR: begin
                    if (w_field_done) begin
                        w_status_next = {w_shift_byte[7:6], 5'b00000, w_shift_byte[0]};
                        w_state_next  = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_status    <= 8'h00;
            r_is_read   <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_load_pend <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_addr      <= w_addr_next;
            r_status    <= w_status_next;
            r_is_read   <= w_is_read_next;
            r_cmd_err   <= w_cmd_err;
            r_load_pend <= w_load_rd;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bit_cnt  <= 4'd0;
            r_shift_in <= 16'h0000;
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt  <= 4'd0;
            r_shift_in <= 16'h0000;
        end else if (w_sclk_rise) begin
            r_shift_in <= w_shift_word;
            r_bit_cnt  <= w_last_bit ? 4'd0 : r_bit_cnt + 4'd1;
        end
    end

    assign w_shifting_out = (w_state_next == ST_RD_DATA) || (w_state_next == ST_RDSR);

    // Read data lands one clk after the array read; the next falling edge is >=4 clk away.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift_out <= 8'h00;
            r_do        <= 1'b0;
        end else begin
            if (w_load_status) begin
                r_shift_out <= r_status;
            end else if (r_load_pend) begin
                r_shift_out <= w_mem_rdata;
            end else if (w_sclk_fall && w_shifting_out) begin
                r_shift_out <= {r_shift_out[6:0], 1'b0};
            end
            if (w_cs_high || !w_shifting_out) begin
                r_do <= 1'b0;
            end else if (w_sclk_fall) begin
                r_do <= r_shift_out[7];
            end
        end
    end

    mkmif_sram_mem #(
        .ADDR_BITS (ADDR_BITS)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_shift_byte),
        .o_rdata (w_mem_rdata)
    );

    assign spi_do  = r_do;
    assign status  = r_status;
    assign cmd_err = r_cmd_err;

endmodule

// File: tb/tb_mkmif_spi_sram.sv
// Directed bench for mkmif_spi_sram: a bit-banged SPI master issues transactions and
// queues the bytes the SRAM must return; a monitor assembles SO bytes and checks them.
module tb_mkmif_spi_sram;

    localparam int HALF = 6;

    logic       clk;
    logic       reset_n;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_di;
    logic       spi_do;
    logic [7:0] status;
    logic       cmd_err;

    logic [7:0] exp_q[$];
    int         checks;
    int         errors;
    int         cmd_err_cnt;
    bit         mon_en;

    mkmif_spi_sram dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_di   (spi_di),
        .spi_do   (spi_do),
        .status   (status),
        .cmd_err  (cmd_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_err === 1'b1) cmd_err_cnt++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver
    task automatic spi_begin();
        spi_cs_n = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic spi_end();
        wait_clk(HALF);
        spi_cs_n = 1'b1;
        wait_clk(10);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n, input bit cap);
        mon_en = cap;
        for (int i = 7; i > 7 - n; i--) begin
            spi_di = b[i];
            wait_clk(HALF);
            spi_sclk = 1'b1;
            wait_clk(HALF);
            spi_sclk = 1'b0;
        end
        mon_en = 1'b0;
        spi_di = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        spi_bits(b, 8, 1'b0);
    endtask

    task automatic do_wrsr(input logic [7:0] v);
        spi_begin();
        spi_byte(8'h01);
        spi_byte(v);
        spi_end();
    endtask

    task automatic do_rdsr(input int n, input logic [7:0] exp);
        spi_begin();
        spi_byte(8'h05);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(exp);
            spi_bits(8'h00, 8, 1'b1);
        end
        spi_end();
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int n);
        spi_begin();
        spi_byte(8'h02);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
        for (int k = 0; k < n; k++) spi_byte(d[31-8*k -: 8]);
        spi_end();
    endtask

    task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input int n);
        spi_begin();
        spi_byte(8'h03);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(exp[31-8*k -: 8]);
            spi_bits(8'h00, 8, 1'b1);
        end
        spi_end();
    endtask

    // scoreboard monitor: SO is sampled on the master's rising SCLK edge
    initial begin
        logic [7:0] sh;
        logic [7:0] e;
        int         cnt;
        sh  = 8'h00;
        cnt = 0;
        forever begin
            @(posedge spi_sclk);
            if (mon_en) begin
                sh = {sh[6:0], spi_do};
                cnt++;
                if (cnt == 8) begin
                    cnt = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL rx_byte: got %02h with nothing expected", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            errors++;
                            $display("FAIL rx_byte: got %02h expected %02h", sh, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5ms;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int cnt_before;
        checks      = 0;
        errors      = 0;
        cmd_err_cnt = 0;
        mon_en      = 1'b0;
        spi_sclk    = 1'b0;
        spi_cs_n    = 1'b1;
        spi_di      = 1'b0;
        reset_n     = 1'b0;
        wait_clk(5);
        reset_n = 1'b1;
        wait_clk(5);

        check("reset_spi_do", {31'd0, spi_do}, 32'd0);
        check("reset_status", {24'd0, status}, 32'h00);
        check("reset_cmd_err", {31'd0, cmd_err}, 32'd0);

        // status register
        do_wrsr(8'h41);
        check("status_41", {24'd0, status}, 32'h41);
        do_rdsr(1, 8'h41);
        do_rdsr(2, 8'h41);

        // sequential mode, with marker bytes for later checks
        do_write(16'h0020, 32'h5A00_0000, 1);
        do_write(16'h0101, 32'h7700_0000, 1);
        do_write(16'h0200, 32'h3300_0000, 1);
        do_write(16'h0010, 32'hDEAD_BEEF, 4);
        do_read(16'h0010, 32'hDEAD_BEEF, 4);

        // page mode wraps inside the 32-byte page
        do_wrsr(8'h80);
        check("status_80", {24'd0, status}, 32'h80);
        do_write(16'h001F, 32'h1122_0000, 2);
        do_read(16'h001F, 32'h1122_0000, 2);
        do_read(16'h0000, 32'h2200_0000, 1);
        do_read(16'h0020, 32'h5A00_0000, 1);

        // sequential wrap at the top of the array
        do_wrsr(8'h41);
        do_write(16'h1FFF, 32'hAABB_0000, 2);
        do_read(16'h0000, 32'hBB00_0000, 1);
        do_read(16'h1FFF, 32'hAABB_0000, 2);

        // byte mode: one byte per transaction, rest ignored
        do_wrsr(8'h00);
        check("status_00", {24'd0, status}, 32'h00);
        do_write(16'h0100, 32'h5566_0000, 2);
        do_read(16'h0100, 32'h5500_0000, 2);
        do_wrsr(8'h41);
        do_read(16'h0101, 32'h7700_0000, 1);

        // unsupported opcode
        cnt_before = cmd_err_cnt;
        spi_begin();
        spi_byte(8'h9F);
        exp_q.push_back(8'h00);
        spi_bits(8'h00, 8, 1'b1);
        exp_q.push_back(8'h00);
        spi_bits(8'h00, 8, 1'b1);
        spi_end();
        check("cmd_err_pulses", cmd_err_cnt - cnt_before, 32'd1);

        // CS abort mid write byte
        spi_begin();
        spi_byte(8'h02);
        spi_byte(8'h02);
        spi_byte(8'h00);
        spi_bits(8'hF0, 4, 1'b0);
        spi_end();
        do_read(16'h0200, 32'h3300_0000, 1);
        check("status_kept", {24'd0, status}, 32'h41);
        check("cmd_err_total", cmd_err_cnt, 32'd1);

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) wait_clk(1);
        check("exp_q_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mkmif_spi_sram.md
# mkmif_spi_sram

Synthesizable SPI slave that emulates the Microchip 23K640 serial SRAM: it is the responder end of the MKM interface's SPI link. It decodes READ, WRITE, RDSR and WRSR transactions in SPI mode 0 and serves them from an internal byte array. It is used as the memory model in core and top-level benches, and as an on-FPGA stand-in when no external SRAM is fitted.

## Interface
- ADDR_BITS, 13, byte-address width of the internal array (8 KiB); the upper bits of the received 16-bit address are ignored.
- PAGE_BYTES, 32, page size for page mode; must be a power of two.
- clk  in  1  system clock; all logic is in this domain.
- reset_n  in  1  reset, asynchronous, active-low.
- spi_sclk  in  1  SPI clock from master, asynchronous to clk.
- spi_cs_n  in  1  chip select, active low, asynchronous.
- spi_di  in  1  serial data master→slave (SRAM SI).
- spi_do  out  1  serial data slave→master (SRAM SO); reset 0.
- status  out  8  current status register; reset 8'h00.
- cmd_err  out  1  one-cycle pulse on an unsupported opcode; reset 0.

## Operation
- spi_sclk, spi_cs_n and spi_di each pass through a 2-flop synchronizer; SCLK rising and falling edges are detected from the synchronized value.
- Mode 0: spi_di is sampled on the detected rising edge, MSB first. spi_do is updated on the detected falling edge.
- spi_do is 0 whenever synchronized CS is high. There is no tristate.
- FSM states: IDLE, CMD, ADDR, RD_DATA, WR_DATA, RDSR, WRSR, IGNORE.
- IDLE→CMD on a CS falling edge. The bit counter and shift register are cleared.
- CMD: after 8 bits, decode the opcode:
  - 0x03→ADDR (read); 0x02→ADDR (write).
  - 0x05→RDSR, loading status into the output shifter.
  - 0x01→WRSR.
  - Any other opcode→IGNORE, with cmd_err asserted for 1 cycle.
- ADDR: after 16 bits, latch addr[ADDR_BITS-1:0], then go to RD_DATA or WR_DATA.
  - For a read, issue the array read immediately. The first data bit drives on the falling edge after the 24th rising edge.
- RD_DATA: shift out the byte MSB first. After 8 bits, advance the address and prefetch the next byte.
- WR_DATA: after 8 bits, write the byte at the current address, then advance the address.
- Address advance depends on status[7:6]:
  - 01 sequential: increment, wrapping 2^ADDR_BITS-1 → 0.
  - 10 page: increment the low log2(PAGE_BYTES) bits only.
  - 00 or 11 byte mode: no advance; go to IGNORE after the first byte. In IGNORE, spi_do is held 0 and writes are suppressed.
- RDSR: shift out status, repeating it for every further byte.
- WRSR: after 8 bits, store bits 7, 6 and 0; bits 5:1 read as 0. The FSM then goes to IGNORE.
- A CS rising edge in any state→IDLE:
  - A partial write byte is discarded.
  - Bytes already completed remain written.
  - The status register is unchanged unless the full WRSR byte was received.
- Async reset mid-transaction: state IDLE, all outputs at reset values. The array contents are not cleared.

## Timing
- Synchronizer plus edge detect adds 3 clk of latency from a pin change to an internal event.
- Each SCLK high and low phase must last ≥4 clk (master divisor ≥4). This leaves time for a 1-cycle synchronous array read before the next falling edge.
- The array write commits 1 clk after the 8th data rising edge is detected.
- status updates 1 clk after the 8th WRSR bit.
- CS setup/hold relative to SCLK must each be ≥3 clk.

## Structure
- Shared package/include mkmif_pkg:
  - opcodes SPI_READ_DATA_CMD=8'h03, SPI_WRITE_DATA_CMD=8'h02, SPI_READ_STATUS_CMD=8'h05, SPI_WRITE_STATUS_CMD=8'h01;
  - mode encodings MODE_BYTE=2'b00, MODE_PAGE=2'b10, MODE_SEQ=2'b01;
  - FSM state constants.
- Sub-module mkmif_sram_mem: single-port 2^ADDR_BITS×8 array with synchronous read and write. It is reusable by other benches.

## Test plan
- WRSR 0x41, then RDSR → 0x41 read back; RDSR for 2 bytes → 0x41, 0x41.
- Sequential mode: WRITE at 0x0010 with bytes DE AD BE EF, then READ at 0x0010 for 4 bytes → DE AD BE EF.
- Page mode (WRSR 0x80): WRITE 11 22 at 0x001F, then READ 0x001F for 2 bytes → 11 22. A separate READ at 0x0000 → 22, and 0x0020 is untouched.
- Sequential wrap: WRITE AA BB at 0x1FFF; READ 0x0000 → BB.
- Byte mode (status 0x00): WRITE 55 66 at 0x0100; READ 0x0100 for 2 bytes → 55 then 00; 0x0101 is unchanged.
- Opcode 0x9F → cmd_err pulses once and spi_do stays 0. Raising CS after 4 bits of a write byte leaves the target byte unchanged, and the next transaction decodes normally.
